// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bus for logic_unit_pipe.
// Zero/Parity flag signals exist only when LOGIC_UNIT_FLAGS_EN is defined.
interface logic_unit_pipe_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       Op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Out;
    logic [CNT_W-1:0] done_count;
`ifdef LOGIC_UNIT_FLAGS_EN
    logic             Zero;
    logic             Parity;

    modport master (
        output in_valid, A, B, Op, out_ready,
        input  in_ready, out_valid, Out, done_count, Zero, Parity
    );
    modport slave (
        input  in_valid, A, B, Op, out_ready,
        output in_ready, out_valid, Out, done_count, Zero, Parity
    );
`else
    modport master (
        output in_valid, A, B, Op, out_ready,
        input  in_ready, out_valid, Out, done_count
    );
    modport slave (
        input  in_valid, A, B, Op, out_ready,
        output in_ready, out_valid, Out, done_count
    );
`endif
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshake and consumed-result counter.
// Optional Zero/Parity result flags are built when LOGIC_UNIT_FLAGS_EN is defined.
module logic_unit_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    logic_unit_pipe_if.slave bus
);
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [2:0]       r_s1_op;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_out;
    logic [CNT_W-1:0] r_done_count;

    logic             w_s1_ready;
    logic             w_s2_ready;
    logic             w_accept;
    logic             w_consume;
    logic [WIDTH-1:0] w_result;

    // Combinational ready chain lets a draining output free both stages in one cycle.
    assign w_s2_ready = ~r_s2_valid | bus.out_ready;
    assign w_s1_ready = ~r_s1_valid | w_s2_ready;
    assign w_accept   = bus.in_valid & w_s1_ready;
    assign w_consume  = r_s2_valid & bus.out_ready;

    always_comb begin
        w_result = r_s1_a;
        case (r_s1_op)
            3'b000:  w_result = r_s1_a & r_s1_b;
            3'b001:  w_result = r_s1_a | r_s1_b;
            3'b010:  w_result = r_s1_a ^ r_s1_b;
            3'b011:  w_result = ~(r_s1_a | r_s1_b);
            3'b100:  w_result = r_s1_a & ~r_s1_b;
            3'b101:  w_result = r_s1_a | ~r_s1_b;
            3'b110:  w_result = ~(r_s1_a ^ r_s1_b);
            default: w_result = r_s1_a;
        endcase
    end

    // Stage 1: operand capture; data held when not loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= '0;
        end else if (w_s1_ready) begin
            r_s1_valid <= bus.in_valid;
            if (w_accept) begin
                r_s1_a  <= bus.A;
                r_s1_b  <= bus.B;
                r_s1_op <= bus.Op;
            end
        end
    end

    // Stage 2: result register; Out keeps its last value when nothing moves in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_out      <= '0;
        end else if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out <= w_result;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_count <= '0;
        end else if (w_consume) begin
            r_done_count <= r_done_count + CNT_W'(1);
        end
    end

`ifdef LOGIC_UNIT_FLAGS_EN
    logic r_zero;
    logic r_parity;

    // Flags travel with Out so they stay coherent through stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero   <= 1'b0;
            r_parity <= 1'b0;
        end else if (w_s2_ready && r_s1_valid) begin
            r_zero   <= ~|w_result;
            r_parity <= ^w_result;
        end
    end

    assign bus.Zero   = r_zero;
    assign bus.Parity = r_parity;
`endif

    assign bus.in_ready   = w_s1_ready;
    assign bus.out_valid  = r_s2_valid;
    assign bus.Out        = r_out;
    assign bus.done_count = r_done_count;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: scoreboard of expected results, checked on each output transfer.
module tb_logic_unit_pipe;
    logic clk;
    logic rst_n;

    logic_unit_pipe_if #(.WIDTH(32), .CNT_W(4)) bus ();

    logic_unit_pipe #(.WIDTH(32), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_tests;
    int          n_fail;
    logic [31:0] sb[$];
    logic [3:0]  exp_cnt;

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a | b);
            3'd4:    return a & ~b;
            3'd5:    return a | ~b;
            3'd6:    return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: record accept/consume just before the edge, then sample 1 time unit after it.
    task automatic step(output bit acc);
        #1;
        acc = bus.in_valid && bus.in_ready;
        if (acc) sb.push_back(model(bus.A, bus.B, bus.Op));
        if (bus.out_valid && bus.out_ready) begin
            n_tests++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_underflow observed=%h expected=none", bus.Out);
            end
            if (sb.size() != 0) chk("out_order", bus.Out, sb.pop_front());
            exp_cnt++;
        end
        @(posedge clk);
        #1;
        chk("done_count", 32'(bus.done_count), 32'(exp_cnt));
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        sb.delete();
        exp_cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [31:0] ops_tab [8];
    logic [31:0] ba [4];
    logic [31:0] bb [4];
    logic [2:0]  bo [4];

    initial begin
        bit          acc;
        int          sent;
        logic [31:0] held;
        logic [3:0]  c0;

        n_tests = 0;
        n_fail  = 0;
        exp_cnt = '0;
        ops_tab = '{32'h0A0A_0505, 32'hAFAF_5F5F, 32'hA5A5_5A5A, 32'h5050_A0A0,
                    32'hA0A0_5050, 32'hFAFA_F5F5, 32'h5A5A_A5A5, 32'hAAAA_5555};
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.Op        = '0;
        rst_n         = 1'b0;

        #3;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out", bus.Out, 32'd0);
        chk("rst_done_count", 32'(bus.done_count), 32'd0);
        do_reset();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Single beat, latency and count.
        bus.A = 32'hF0F0_1234; bus.B = 32'hFF00_00FF; bus.Op = 3'b000;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        step(acc);
        chk("single_acc", 32'(acc), 32'd1);
        bus.in_valid = 1'b0;
        chk("single_lat1_valid", 32'(bus.out_valid), 32'd0);
        step(acc);
        chk("single_lat2_valid", 32'(bus.out_valid), 32'd1);
        chk("single_out", bus.Out, 32'hF000_0034);
        step(acc);
        chk("single_drained", 32'(bus.out_valid), 32'd0);
        chk("single_count", 32'(bus.done_count), 32'd1);

        // All eight ops back-to-back at full throughput.
        bus.A = 32'hAAAA_5555; bus.B = 32'h0F0F_0F0F; bus.in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.Op = 3'(k);
            step(acc);
            chk("ops_acc", 32'(acc), 32'd1);
            if (k == 0) chk("ops_fill", 32'(bus.out_valid), 32'd0);
            else begin
                chk("ops_valid", 32'(bus.out_valid), 32'd1);
                chk("ops_out", bus.Out, ops_tab[k-1]);
            end
        end
        bus.in_valid = 1'b0;
        step(acc);
        chk("ops_last_valid", 32'(bus.out_valid), 32'd1);
        chk("ops_last_out", bus.Out, ops_tab[7]);
        for (int g = 0; g < 10 && bus.out_valid; g++) step(acc);
        chk("ops_drain", 32'(bus.out_valid), 32'd0);
        chk("ops_sb_empty", 32'(sb.size()), 32'd0);

        // Backpressure: two beats fill the pipe, then input stalls with Out held.
        for (int i = 0; i < 4; i++) begin
            ba[i] = $urandom; bb[i] = $urandom; bo[i] = 3'(i + 1);
        end
        c0 = exp_cnt;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.A = ba[i]; bus.B = bb[i]; bus.Op = bo[i]; bus.in_valid = 1'b1;
            step(acc);
            chk("bp_acc", 32'(acc), 32'd1);
        end
        bus.A = ba[2]; bus.B = bb[2]; bus.Op = bo[2];
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        held = model(ba[0], bb[0], bo[0]);
        for (int s = 0; s < 3; s++) begin
            step(acc);
            chk("bp_stall_acc", 32'(acc), 32'd0);
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_hold_out", bus.Out, held);
        end
        bus.out_ready = 1'b1;
        sent = 2;
        for (int g = 0; g < 20 && (sent < 4 || bus.out_valid); g++) begin
            if (sent < 4) begin
                bus.A = ba[sent]; bus.B = bb[sent]; bus.Op = bo[sent]; bus.in_valid = 1'b1;
            end else bus.in_valid = 1'b0;
            step(acc);
            if (acc) sent++;
        end
        bus.in_valid = 1'b0;
        chk("bp_sent", 32'(sent), 32'd4);
        chk("bp_drain", 32'(bus.out_valid), 32'd0);
        chk("bp_sb_empty", 32'(sb.size()), 32'd0);
        chk("bp_count", 32'(bus.done_count), 32'(4'(c0 + 4'd4)));

        // Counter wrap with a 4-bit counter: 17 results leave it at 1.
        do_reset();
        bus.out_ready = 1'b1;
        sent = 0;
        for (int g = 0; g < 40 && (sent < 17 || bus.out_valid); g++) begin
            if (sent < 17) begin
                bus.A = $urandom; bus.B = $urandom; bus.Op = 3'($urandom_range(0, 7));
                bus.in_valid = 1'b1;
            end else bus.in_valid = 1'b0;
            step(acc);
            if (acc) sent++;
        end
        bus.in_valid = 1'b0;
        chk("wrap_sent", 32'(sent), 32'd17);
        chk("wrap_count", 32'(bus.done_count), 32'd1);

        // Asynchronous reset with both stages occupied.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.A = ba[i]; bus.B = bb[i]; bus.Op = bo[i]; bus.in_valid = 1'b1;
            step(acc);
        end
        bus.in_valid = 1'b0;
        chk("mid_full_valid", 32'(bus.out_valid), 32'd1);
        chk("mid_full_in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_out", bus.Out, 32'd0);
        chk("mid_rst_count", 32'(bus.done_count), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        do_reset();
        bus.A = 32'hFFFF_0000; bus.B = 32'h0F0F_0F0F; bus.Op = 3'b100;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        step(acc);
        bus.in_valid = 1'b0;
        chk("post_rst_lat1", 32'(bus.out_valid), 32'd0);
        step(acc);
        chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
        chk("post_rst_out", bus.Out, 32'hF0F0_0000);
        step(acc);
        chk("post_rst_count", 32'(bus.done_count), 32'd1);

`ifdef LOGIC_UNIT_FLAGS_EN
        bus.A = 32'h1234_5678; bus.B = 32'h1234_5678; bus.Op = 3'b010; bus.in_valid = 1'b1;
        step(acc);
        bus.in_valid = 1'b0;
        step(acc);
        chk("flag_xor_out", bus.Out, 32'd0);
        chk("flag_zero1", 32'(bus.Zero), 32'd1);
        chk("flag_parity0", 32'(bus.Parity), 32'd0);
        bus.A = 32'h0000_0007; bus.B = 32'd0; bus.Op = 3'b111; bus.in_valid = 1'b1;
        step(acc);
        bus.in_valid = 1'b0;
        step(acc);
        chk("flag_pass_out", bus.Out, 32'h0000_0007);
        chk("flag_zero0", 32'(bus.Zero), 32'd0);
        chk("flag_parity1", 32'(bus.Parity), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
